// File: rtl/osd_pkg.sv
// Shared OSD scheduler types: FSM state encoding, config word bit positions and register map.
// No logic of its own.
package osd_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRWORD,
        ST_WRCFG,
        ST_CLOSE
    } osd_state_e;

    localparam int RENDER_EN      = 0;
    localparam int STATUS_REFRESH = 1;
    localparam int MENU_ACTIVE    = 2;

    localparam logic [3:0] OSD_CONFIG_REGNUM = 4'd0;
endpackage

// File: rtl/osd_req_arbiter.sv
// Combinational requester picker: fixed req0 > req1, or round-robin under OSD_SCHED_ROUND_ROBIN_EN.
// Zero latency; never stalls, only chooses among requesters that are valid this cycle.
module osd_req_arbiter (
    input  logic [1:0] req_i,
    input  logic       last_i,   // high when requester 1 was granted most recently
    output logic [1:0] gnt_o
);
`ifdef OSD_SCHED_ROUND_ROBIN_EN
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end
    end
`else
    logic unused_last;
    assign unused_last = last_i;

    always_comb begin
        gnt_o = 2'b00;
        if (req_i[0]) begin
            gnt_o = 2'b01;
        end else if (req_i[1]) begin
            gnt_o = 2'b10;
        end
    end
`endif
endmodule

// File: rtl/osd_update_sched.sv
// OSD update scheduler: packs granted requester's characters into words, writes them then the config word over Avalon-MM.
// Word write is issued 1 cycle after its 4th char and held on waitrequest; OSD_SCHED_ROUND_ROBIN_EN selects round-robin arbitration.
module osd_update_sched
    import osd_pkg::*;
#(
    parameter int CHAR_COLS = 16,
    parameter int CHAR_ROWS = 2,
    localparam int RW = (CHAR_ROWS > 1) ? $clog2(CHAR_ROWS) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [15:0]     req_data,
    input  logic [2*RW-1:0] req_row,
    input  logic            menu_close,
    input  logic [31:0]     cfg_base,
    output logic [3:0]      avm_address,
    output logic [31:0]     avm_writedata,
    output logic [3:0]      avm_byteenable,
    output logic            avm_write,
    input  logic            avm_waitrequest_n,
    output logic [1:0]      grant,
    output logic            busy
);
    localparam int WORDS = CHAR_COLS / 4;
    localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    osd_state_e    state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic [RW-1:0] row_q, row_d;
    logic [1:0]    byte_q, byte_d;
    logic [WW-1:0] word_q, word_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          close_pending_q, close_pending_d;
    logic          menu_active_q, menu_active_d;
    logic          last_q, last_d;
    logic [1:0]    arb_gnt;
    logic [7:0]    char_in;
    logic [31:0]   addr_full;
    logic          unused_addr_hi;

    osd_req_arbiter u_arb (
        .req_i  (req_valid),
        .last_i (last_q),
        .gnt_o  (arb_gnt)
    );

    assign char_in        = grant_q[1] ? req_data[15:8] : req_data[7:0];
    assign addr_full      = 32'(row_q) * 32'(WORDS) + 32'(word_q) + 32'd1;
    assign unused_addr_hi = ^addr_full[31:4];
    assign busy           = (state_q != ST_IDLE);
    assign grant          = (state_q == ST_COLLECT || state_q == ST_WRWORD || state_q == ST_WRCFG)
                            ? grant_q : 2'b00;

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        row_d           = row_q;
        byte_d          = byte_q;
        word_d          = word_q;
        wdata_d         = wdata_q;
        close_pending_d = close_pending_q | menu_close;
        menu_active_d   = menu_active_q;
        last_d          = last_q;
        req_ready       = 2'b00;
        avm_write       = 1'b0;
        avm_address     = 4'd0;
        avm_writedata   = 32'd0;
        avm_byteenable  = 4'd0;
        case (state_q)
            ST_IDLE: begin
                // A close seen this very cycle already outranks any requester
                if (close_pending_q || menu_close) begin
                    state_d = ST_CLOSE;
                end else if (|arb_gnt) begin
                    state_d = ST_COLLECT;
                    grant_d = arb_gnt;
                    last_d  = arb_gnt[1];
                    row_d   = arb_gnt[1] ? req_row[2*RW-1:RW] : req_row[RW-1:0];
                    byte_d  = 2'd0;
                    word_d  = '0;
                end
            end
            ST_COLLECT: begin
                req_ready = grant_q;
                if (|(req_valid & grant_q)) begin
                    wdata_d[8*byte_q +: 8] = char_in;
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        state_d = ST_WRWORD;
                    end
                end
            end
            ST_WRWORD: begin
                avm_write      = 1'b1;
                avm_byteenable = 4'hF;
                avm_address    = addr_full[3:0];
                avm_writedata  = wdata_q;
                if (avm_waitrequest_n) begin
                    if (word_q == WW'(WORDS - 1)) begin
                        state_d = ST_WRCFG;
                        word_d  = '0;
                    end else begin
                        state_d = ST_COLLECT;
                        word_d  = word_q + WW'(1);
                    end
                end
            end
            ST_WRCFG: begin
                avm_write      = 1'b1;
                avm_byteenable = 4'hF;
                avm_address    = OSD_CONFIG_REGNUM;
                if (grant_q[0]) begin
                    avm_writedata = cfg_base | (32'd1 << RENDER_EN) | (32'd1 << MENU_ACTIVE);
                end else begin
                    avm_writedata = cfg_base | (32'd1 << RENDER_EN) | (32'd1 << STATUS_REFRESH);
                    avm_writedata[MENU_ACTIVE] = menu_active_q;
                end
                if (avm_waitrequest_n) begin
                    state_d = ST_IDLE;
                    if (grant_q[0]) begin
                        menu_active_d = 1'b1;
                    end
                end
            end
            ST_CLOSE: begin
                avm_write      = 1'b1;
                avm_byteenable = 4'hF;
                avm_address    = OSD_CONFIG_REGNUM;
                avm_writedata  = (cfg_base | (32'd1 << RENDER_EN)) & ~(32'd1 << MENU_ACTIVE);
                if (avm_waitrequest_n) begin
                    state_d         = ST_IDLE;
                    menu_active_d   = 1'b0;
                    // A fresh pulse landing on the completion cycle stays pending
                    close_pending_d = menu_close;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= ST_IDLE;
            grant_q         <= 2'b00;
            row_q           <= '0;
            byte_q          <= 2'd0;
            word_q          <= '0;
            wdata_q         <= 32'd0;
            close_pending_q <= 1'b0;
            menu_active_q   <= 1'b0;
            last_q          <= 1'b1;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            row_q           <= row_d;
            byte_q          <= byte_d;
            word_q          <= word_d;
            wdata_q         <= wdata_d;
            close_pending_q <= close_pending_d;
            menu_active_q   <= menu_active_d;
            last_q          <= last_d;
        end
    end
endmodule

// File: tb/tb_osd_update_sched.sv
// Bench for osd_update_sched: table-driven line scenarios, hand sequences for arbitration/close/reset, randomized lines.
// Expected Avalon writes come from a line-level model of the character/word/config rules.
module tb_osd_update_sched;
    localparam int CC = 16;
    localparam logic [31:0] CFG = 32'h0012_3400;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_data;
    logic [1:0]  req_row;
    logic        menu_close = 1'b0;
    logic [31:0] cfg_base;
    logic [3:0]  avm_address;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_write;
    logic        avm_waitrequest_n = 1'b1;
    logic [1:0]  grant;
    logic        busy;

    osd_update_sched dut (
        .clk_i (clk_i), .rst_i (rst_i),
        .req_valid (req_valid), .req_ready (req_ready), .req_data (req_data), .req_row (req_row),
        .menu_close (menu_close), .cfg_base (cfg_base),
        .avm_address (avm_address), .avm_writedata (avm_writedata), .avm_byteenable (avm_byteenable),
        .avm_write (avm_write), .avm_waitrequest_n (avm_waitrequest_n),
        .grant (grant), .busy (busy)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]  chars [2][CC];
    logic [3:0]  got_addr [$];
    logic [31:0] got_data [$];
    logic [3:0]  exp_addr [$];
    logic [31:0] exp_data [$];
    int got_rd = 0;
    int err_seen = 0;
    int m_menu = 0;
    int m_last = 1;

    // Slave side: owned by the monitor process only
    int stall_target = 0;
    bit stall_rand = 1'b0;
    int close_req = 0;
    int wr_close_req = 0;
    int close_served = 0;
    int wr_close_served = 0;
    int mon_err = 0;
    int stall_cnt = 0;
    int cur_target = 0;
    bit stalled = 1'b0;
    logic [3:0]  p_addr;
    logic [31:0] p_data;

    always begin
        @(negedge clk_i);
        #1;
        menu_close = 1'b0;
        if (close_req != close_served) begin
            menu_close = 1'b1;
            close_served = close_req;
        end else if (wr_close_req != wr_close_served && avm_write && grant[1] && avm_address != 4'd0) begin
            menu_close = 1'b1;
            wr_close_served = wr_close_req;
        end
        if (rst_i) begin
            avm_waitrequest_n = 1'b0;
            stall_cnt = 0;
            stalled = 1'b0;
        end else if (avm_write) begin
            if (stalled) begin
                if (avm_address !== p_addr || avm_writedata !== p_data) mon_err++;
            end else begin
                cur_target = stall_rand ? int'($urandom_range(0, 2)) : stall_target;
            end
            if (stall_cnt < cur_target) begin
                avm_waitrequest_n = 1'b0;
                stall_cnt++;
                stalled = 1'b1;
                p_addr = avm_address;
                p_data = avm_writedata;
            end else begin
                avm_waitrequest_n = 1'b1;
                if (avm_byteenable !== 4'hF) mon_err++;
                got_addr.push_back(avm_address);
                got_data.push_back(avm_writedata);
                stall_cnt = 0;
                stalled = 1'b0;
            end
        end else begin
            avm_waitrequest_n = 1'b1;
            stalled = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: cycle budget expired", name);
    endtask

    // Line model: CC/4 words little-endian packed at 1+row*(CC/4)+w, then the config word
    task automatic model_line(input int req, input int row);
        for (int w = 0; w < CC / 4; w++) begin
            exp_addr.push_back(4'(1 + row * (CC / 4) + w));
            exp_data.push_back({chars[req][4*w+3], chars[req][4*w+2], chars[req][4*w+1], chars[req][4*w]});
        end
        exp_addr.push_back(4'd0);
        if (req == 0) begin
            exp_data.push_back(cfg_base | 32'h5);
            m_menu = 1;
        end else begin
            exp_data.push_back(((cfg_base | 32'h3) & ~32'h4) | ((m_menu != 0) ? 32'h4 : 32'h0));
        end
        m_last = req;
    endtask

    task automatic model_close();
        exp_addr.push_back(4'd0);
        exp_data.push_back((cfg_base | 32'h1) & ~32'h4);
        m_menu = 0;
    endtask

    task automatic compare_writes(input string tag);
        int n;
        n = got_addr.size() - got_rd;
        check({tag, "_write_count"}, n, exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), got_addr[got_rd+i], exp_addr[i]);
            check($sformatf("%s_data%0d", tag, i), got_data[got_rd+i], exp_data[i]);
        end
        check({tag, "_bus_hold_and_be"}, mon_err, err_seen);
        err_seen = mon_err;
        got_rd = got_addr.size();
        exp_addr.delete();
        exp_data.delete();
    endtask

    // Idle must be seen on two consecutive cycles: a pending close re-enters busy after one idle cycle
    task automatic settle(input string tag);
        int low;
        int cyc;
        low = 0;
        cyc = 0;
        while (low < 2 && cyc < 400) begin
            @(negedge clk_i);
            cyc++;
            if (!busy) low++;
            else low = 0;
        end
        if (low < 2) timeout_fail({tag, "_settle"});
    endtask

    task automatic run_lines(input logic [1:0] en, input logic [1:0] rows, input string tag);
        int idx [2];
        bit chk [2];
        int cyc;
        idx[0] = 0; idx[1] = 0;
        chk[0] = 1'b0; chk[1] = 1'b0;
        cyc = 0;
        while (((en[0] && idx[0] < CC) || (en[1] && idx[1] < CC)) && cyc < 600) begin
            @(negedge clk_i);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (chk[i]) begin
                    check({tag, "_word_write_latency"}, avm_write, 1'b1);
                    check({tag, "_ready_drop"}, req_ready[i], 1'b0);
                    chk[i] = 1'b0;
                end
            end
            for (int i = 0; i < 2; i++) begin
                req_valid[i] = en[i] && (idx[i] < CC);
                req_data[8*i +: 8] = chars[i][(idx[i] < CC) ? idx[i] : 0];
                req_row[i] = (idx[i] == 0) ? rows[i] : ~rows[i];
            end
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    if (idx[i] % 4 == 3) chk[i] = 1'b1;
                    idx[i]++;
                end
            end
        end
        if (cyc >= 600) timeout_fail({tag, "_chars"});
        @(negedge clk_i);
        for (int i = 0; i < 2; i++) begin
            if (chk[i]) begin
                check({tag, "_word_write_latency"}, avm_write, 1'b1);
                check({tag, "_ready_drop"}, req_ready[i], 1'b0);
            end
        end
        req_valid = 2'b00;
        settle(tag);
    endtask

    typedef struct {
        int          req;
        int          row;
        logic [7:0]  first;
        int          stall;
        logic [3:0]  e_addr;
        logic [31:0] e_w0;
        logic [31:0] e_wl;
        logic [31:0] e_cfg;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl [4];
        int   first;
        int   idx;
        int   cyc;
        int   rq;
        int   rw;

        tbl[0] = '{0, 0, 8'h41, 0, 4'd1, 32'h44434241, 32'h504F4E4D, 32'h00123405};
        tbl[1] = '{1, 1, 8'h61, 3, 4'd5, 32'h64636261, 32'h706F6E6D, 32'h00123407};
        tbl[2] = '{1, 0, 8'h20, 1, 4'd1, 32'h23222120, 32'h2F2E2D2C, 32'h00123407};
        tbl[3] = '{0, 1, 8'h30, 2, 4'd5, 32'h33323130, 32'h3F3E3D3C, 32'h00123405};

        rst_i = 1'b1;
        req_valid = 2'b00;
        req_data = 16'h0;
        req_row = 2'b00;
        cfg_base = CFG;
        repeat (3) @(negedge clk_i);
        check("rst_avm_write", avm_write, 1'b0);
        check("rst_avm_address", avm_address, 4'd0);
        check("rst_avm_writedata", avm_writedata, 32'd0);
        check("rst_avm_byteenable", avm_byteenable, 4'd0);
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_grant", grant, 2'b00);
        check("rst_busy", busy, 1'b0);
        rst_i = 1'b0;
        @(negedge clk_i);

        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < CC; k++) chars[tbl[t].req][k] = tbl[t].first + 8'(k);
            stall_target = tbl[t].stall;
            model_line(tbl[t].req, tbl[t].row);
            run_lines((tbl[t].req == 0) ? 2'b01 : 2'b10, (tbl[t].row == 0) ? 2'b00 : 2'b11, "tbl");
            if (got_addr.size() - got_rd >= 5) begin
                check("tbl_first_addr", got_addr[got_rd], tbl[t].e_addr);
                check("tbl_first_word", got_data[got_rd], tbl[t].e_w0);
                check("tbl_last_word", got_data[got_rd+3], tbl[t].e_wl);
                check("tbl_cfg_addr", got_addr[got_rd+4], 4'd0);
                check("tbl_cfg_data", got_data[got_rd+4], tbl[t].e_cfg);
            end
            compare_writes("tbl");
        end

        // Both requesters raise valid together; req0 on row 0, req1 on row 1
        for (int k = 0; k < CC; k++) begin
            chars[0][k] = 8'h80 + 8'(k);
            chars[1][k] = 8'hA0 + 8'(k);
        end
        stall_target = 0;
`ifdef OSD_SCHED_ROUND_ROBIN_EN
        first = (m_last == 0) ? 1 : 0;
`else
        first = 0;
`endif
        model_line(first, first);
        model_line(1 - first, 1 - first);
        run_lines(2'b11, 2'b10, "both");
        compare_writes("both");

        // Close pulse while req1 is stalled in a word write
        for (int k = 0; k < CC; k++) chars[1][k] = 8'hC0 + 8'(k);
        stall_target = 3;
        wr_close_req++;
        model_line(1, 0);
        model_close();
        run_lines(2'b10, 2'b00, "close");
        check("close_busy_after", busy, 1'b0);
        compare_writes("close");

        // Reset while a word write is held by waitrequest
        stall_target = 1000;
        for (int k = 0; k < CC; k++) chars[0][k] = 8'h41 + 8'(k);
        idx = 0;
        cyc = 0;
        while (!avm_write && cyc < 100) begin
            @(negedge clk_i);
            cyc++;
            req_valid = 2'b01;
            req_row = 2'b00;
            req_data[7:0] = chars[0][idx];
            if (req_ready[0]) idx++;
        end
        if (cyc >= 100) timeout_fail("rst_mid_write_start");
        repeat (2) @(negedge clk_i);
        check("rst_pre_write", avm_write, 1'b1);
        check("rst_pre_wait", avm_waitrequest_n, 1'b0);
        rst_i = 1'b1;
        req_valid = 2'b00;
        @(negedge clk_i);
        check("rst_mid_avm_write", avm_write, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_grant", grant, 2'b00);
        check("rst_mid_ready", req_ready, 2'b00);
        check("rst_mid_address", avm_address, 4'd0);
        rst_i = 1'b0;
        stall_target = 0;
        m_menu = 0;
        m_last = 1;
        exp_addr.delete();
        exp_data.delete();
        got_rd = got_addr.size();
        @(negedge clk_i);
        model_line(0, 0);
        run_lines(2'b01, 2'b00, "rst_restart");
        if (got_addr.size() > got_rd) check("rst_restart_word0_addr", got_addr[got_rd], 4'd1);
        compare_writes("rst_restart");

        // Randomized lines with random wait states and occasional idle-time close
        stall_rand = 1'b1;
        for (int it = 0; it < 12; it++) begin
            rq = int'($urandom_range(0, 1));
            rw = int'($urandom_range(0, 1));
            for (int k = 0; k < CC; k++) chars[rq][k] = 8'($urandom);
            model_line(rq, rw);
            run_lines((rq == 0) ? 2'b01 : 2'b10, (rw == 0) ? 2'b00 : 2'b11, "rand");
            if ($urandom_range(0, 3) == 0) begin
                close_req++;
                model_close();
                settle("rand_close");
            end
            compare_writes("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/osd_update_sched.md
OSD_UPDATE_SCHED -- requirements
Module: osd_update_sched

Interface
REQ-001 Parameter CHAR_COLS, default 16, characters per OSD line; SHALL be a multiple of 4.
REQ-002 Parameter CHAR_ROWS, default 2, number of OSD lines; row index width is $clog2(CHAR_ROWS), minimum 1.
REQ-003 Port clk_i  input  1  single clock for the whole block.
REQ-004 Port rst_i  input  1  synchronous, active-high reset.
REQ-005 Port req_valid  input  2  per-requester character valid; bit0 is the menu requester, bit1 is the status requester.
REQ-006 Port req_ready  output  2  per-requester character accept.
REQ-007 Port req_data  input  16  character codes; req_data[8*i+:8] belongs to requester i.
REQ-008 Port req_row  input  2  target row per requester; sampled only at grant.
REQ-009 Port menu_close  input  1  single-cycle pulse requesting menu deactivation.
REQ-010 Port cfg_base  input  32  base OSD config word (render enable, timeout, offsets, sizes).
REQ-011 Port avm_address  output  4  Avalon-MM master word address into the OSD generator.
REQ-012 Port avm_writedata  output  32  write data.
REQ-013 Port avm_byteenable  output  4  write byte enables; always 4'hF when writing.
REQ-014 Port avm_write  output  1  write strobe.
REQ-015 Port avm_waitrequest_n  input  1  slave ready.
REQ-016 Port grant  output  2  one-hot current owner; 0 when idle or closing.
REQ-017 Port busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have five states: IDLE, COLLECT, WRWORD, WRCFG, CLOSE.
- IDLE: close is pending -> CLOSE.
- IDLE: otherwise, any req_valid -> COLLECT after arbitration (REQ-019), latching grant and row.
REQ-019 Arbitration SHALL give a pending close priority over req0, and req0 priority over req1.
REQ-020 menu_close SHALL set a sticky close_pending flag; the flag SHALL clear when the CLOSE write completes. A pulse arriving during any state SHALL be serviced no later than the next IDLE.
REQ-021 In COLLECT, req_ready[grant] SHALL be high and every other bit low; each accepted character (valid and ready) SHALL be placed in byte (k mod 4), where k is the character index 0..CHAR_COLS-1.
REQ-022 On the 4th character of a word, the next state SHALL be WRWORD, and req_ready SHALL drop in that cycle's successor.
REQ-023 WRWORD SHALL drive the following until a clock edge samples avm_waitrequest_n high; address, data and byteenable SHALL stay stable throughout:
- avm_write=1
- avm_address = 1 + row*(CHAR_COLS/4) + k/4 (4-bit truncation)
- avm_writedata = packed word
REQ-024 After a WRWORD acceptance: if the word was the last one of the line -> WRCFG; otherwise -> COLLECT.
REQ-025 WRCFG SHALL write address 0 with one of the following, then go to IDLE:
- requester 0: data = cfg_base | 32'h5 (render enable and menu active)
- requester 1: data = (cfg_base | 32'h3) with bit2 equal to the internally tracked menu_active
REQ-026 CLOSE SHALL write address 0 with data = (cfg_base | 32'h1) & ~32'h4, then go to IDLE and clear menu_active.
REQ-027 The internal menu_active bit SHALL set on completion of a requester-0 WRCFG.
REQ-028 Minimum latency from the 4th accepted character to avm_write high SHALL be 1 cycle; a full 16-character line with zero wait states SHALL complete in 16 + 4 + 1 write cycles plus the per-word pipeline.
REQ-029 If a requester drops req_valid mid-line, the FSM SHALL hold COLLECT indefinitely; there is no timeout and no partial-word write.
REQ-030 req_row SHALL be sampled only on the grant cycle; later changes SHALL have no effect on the current line.

Reset
REQ-031 rst_i SHALL apply at the next clock edge in any state, including mid-WRWORD, and SHALL force:
- state=IDLE
- avm_write=0, avm_address=0, avm_writedata=0, avm_byteenable=0
- req_ready=0, grant=0, busy=0
- close_pending=0, menu_active=0
- character and word counters = 0

Configuration
REQ-032 With macro OSD_SCHED_ROUND_ROBIN_EN defined, arbitration between req0 and req1 SHALL be round-robin: the requester granted last has lower priority on a tie, and close keeps top priority. Without the macro, the fixed priority of REQ-019 SHALL apply.

Structure
REQ-033 A shared package osd_pkg SHALL hold the state enum, the config bit positions (RENDER_EN=0, STATUS_REFRESH=1, MENU_ACTIVE=2) and the register address constant OSD_CONFIG_REGNUM=0.
REQ-034 The arbiter SHALL be a sub-module osd_req_arbiter (fixed or round-robin, selected by the macro); all other logic SHALL be in one module.

Verification
REQ-035 Req0 line, row 0, chars 0x41..0x50, waitrequest_n=1 -> writes in order:
- addr1=0x44434241, addr2=0x48474645, addr3=0x4C4B4A49, addr4=0x504F4E4D
- addr0 = cfg_base|5
REQ-036 Req1 line, row 1, waitrequest_n low for 3 cycles per write -> addresses 5..8 then 0; data and address held stable across the stalls; addr0 bit1=1.
REQ-037 Both requesters valid in the same cycle (fixed mode) -> req0 line completes first, then req1; with OSD_SCHED_ROUND_ROBIN_EN and req0 granted last -> req1 first.
REQ-038 menu_close pulse during a req1 WRWORD -> req1 line and its cfg write finish, then one addr0 write with bit2=0; busy drops afterwards.
REQ-039 rst_i asserted while avm_write=1 and waitrequest_n=0 -> next cycle avm_write=0, state IDLE, and a subsequent line starts again at word 0.
